// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU input sequencer.
// Holds the stage encoding, control-bit layout and the packed command word.
package alsu_pkg;

  localparam int OPW   = 3;
  localparam int CTRLW = 7;

  // Bit positions of the control switches, matching sw[6:0]
  localparam int CTRL_CIN   = 0;
  localparam int CTRL_SER   = 1;
  localparam int CTRL_RED_A = 2;
  localparam int CTRL_RED_B = 3;
  localparam int CTRL_BYP_A = 4;
  localparam int CTRL_BYP_B = 5;
  localparam int CTRL_DIR   = 6;

  typedef enum logic [2:0] {
    ST_A     = 3'd0,
    ST_B     = 3'd1,
    ST_OP    = 3'd2,
    ST_CTRL  = 3'd3,
    ST_ISSUE = 3'd4
  } st_e;

  typedef struct packed {
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic [OPW-1:0]   op;
    logic [CTRLW-1:0] ctrl;
  } cmd_t;

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes one push-button, debounces it, and emits a one-cycle press pulse.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from a stable edge; no backpressure.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter only survives while the synced level disagrees with the accepted one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= synced;
        cnt   <= '0;
        press <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alsu_input_sequencer.sv
// Loads A, B, opcode and control bits from switches in four button-driven stages, then issues them at once.
// Issue lands two cycles after the final next event; no backpressure, outputs hold until the next issue.
module alsu_input_sequencer
  import alsu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CTRLW-1:0] sw_raw,
  input  logic             btn_next_raw,
  input  logic             btn_clr_raw,
  output logic [OPW-1:0]   A,
  output logic [OPW-1:0]   B,
  output logic [OPW-1:0]   opcode,
  output logic             cin,
  output logic             serial_in,
  output logic             red_op_A,
  output logic             red_op_B,
  output logic             bypass_A,
  output logic             bypass_B,
  output logic             direction,
  output logic             issue,
  output logic [2:0]       stage,
  output logic             busy
);

  logic [CTRLW-1:0] sw_sync [SYNC_STAGES];
  logic [CTRLW-1:0] sw;
  logic             next_ev;
  logic             clr_ev;
  logic             clr_take;
  st_e              state;
  st_e              state_nxt;
  cmd_t             shadow;
  cmd_t             out_q;

  // Switches are levels sampled on a button event, so synchronizing is enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  assign sw = sw_sync[SYNC_STAGES-1];

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next_raw),
    .press   (next_ev)
  );

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr_raw),
    .press   (clr_ev)
  );

  // The issue cycle always completes, even if clear arrives during it
  assign clr_take = clr_ev && (state != ST_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_A:     if (next_ev) state_nxt = ST_B;
      ST_B:     if (next_ev) state_nxt = ST_OP;
      ST_OP:    if (next_ev) state_nxt = ST_CTRL;
      ST_CTRL:  if (next_ev) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_A;
      default:  state_nxt = ST_A;
    endcase
    if (clr_take) state_nxt = ST_A;
  end

  always_comb begin
    stage = state;
    busy  = (state != ST_A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (clr_take) begin
      shadow <= '0;
    end else if (next_ev) begin
      case (state)
        ST_A:    shadow.a    <= sw[OPW-1:0];
        ST_B:    shadow.b    <= sw[OPW-1:0];
        ST_OP:   shadow.op   <= sw[OPW-1:0];
        ST_CTRL: shadow.ctrl <= sw;
        default: ;
      endcase
    end
  end

  // Outputs only ever load as a whole command, so the ALSU never sees a partial one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      issue <= 1'b0;
    end else begin
      issue <= (state == ST_ISSUE);
      if (state == ST_ISSUE) out_q <= shadow;
    end
  end

  assign A         = out_q.a;
  assign B         = out_q.b;
  assign opcode    = out_q.op;
  assign cin       = out_q.ctrl[CTRL_CIN];
  assign serial_in = out_q.ctrl[CTRL_SER];
  assign red_op_A  = out_q.ctrl[CTRL_RED_A];
  assign red_op_B  = out_q.ctrl[CTRL_RED_B];
  assign bypass_A  = out_q.ctrl[CTRL_BYP_A];
  assign bypass_B  = out_q.ctrl[CTRL_BYP_B];
  assign direction = out_q.ctrl[CTRL_DIR];

endmodule
